// File: rtl/cpu_pkg.sv
// Shared LEGv8 CPU definitions: datapath widths, fetch FSM states and address helpers.
package cpu_pkg;

    localparam int ADDR_W  = 64;
    localparam int INSTR_W = 32;

    localparam logic [ADDR_W-1:0]  PC_STEP   = 64'd4;
    localparam logic [INSTR_W-1:0] HALT_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_e;

    // Branch targets are always word aligned; low two bits are dropped on load.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return addr & ~64'd3;
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: instruction-memory request/response, branch redirect and the
// valid/ready link to decode. master = fetch stage, slave = its environment.
interface instruction_fetch_if;
    import cpu_pkg::*;

    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_valid;
    logic [INSTR_W-1:0] imem_data;
    logic               PCSrc;
    logic [ADDR_W-1:0]  BranchAddress;
    logic               if_valid;
    logic               id_ready;
    logic [INSTR_W-1:0] Instruction;
    logic [ADDR_W-1:0]  Address;
    logic               halted;

    modport master (
        output imem_req, imem_addr, if_valid, Instruction, Address, halted,
        input  imem_valid, imem_data, PCSrc, BranchAddress, id_ready
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, Instruction, Address, halted,
        output imem_valid, imem_data, PCSrc, BranchAddress, id_ready
    );

endinterface

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of {address, instruction} pairs between fetch and decode.
// DEPTH must be a power of two; the head entry is read straight from storage registers.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_push,
    input  logic               i_pop,
    input  logic               i_flush,
    input  logic [ADDR_W-1:0]  i_addr,
    input  logic [INSTR_W-1:0] i_instr,
    output logic               o_full,
    output logic               o_empty,
    output logic [CW-1:0]      o_count,
    output logic [ADDR_W-1:0]  o_head_addr,
    output logic [INSTR_W-1:0] o_head_instr
);

    localparam int PW = CW - 1;

    logic [ADDR_W-1:0]  r_addr  [DEPTH];
    logic [INSTR_W-1:0] r_instr [DEPTH];
    logic [PW-1:0]      r_wr_ptr;
    logic [PW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == {CW{1'b0}});
    assign w_pop   = i_pop && !w_empty;
    // A push into a full queue is only accepted when the head leaves in the same cycle.
    assign w_push  = i_push && (!w_full || w_pop);

    // Pointer, occupancy and storage update; flush drops contents but keeps stale data.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            r_count  <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i]  <= {ADDR_W{1'b0}};
                r_instr[i] <= {INSTR_W{1'b0}};
            end
        end else if (i_flush) begin
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_push) begin
                r_addr[r_wr_ptr]  <= i_addr;
                r_instr[r_wr_ptr] <= i_instr;
                r_wr_ptr          <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    assign o_full       = w_full;
    assign o_empty      = w_empty;
    assign o_count      = r_count;
    assign o_head_addr  = r_addr[r_rd_ptr];
    assign o_head_instr = r_instr[r_rd_ptr];

endmodule

// File: rtl/instruction_fetch.sv
// LEGv8 fetch stage: PC, single-outstanding instruction-memory reads, fetch queue and
// branch redirect/flush. Optional halt-on-zero-word behaviour under IFETCH_HALT_EN.
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC    = 64'h0,
    parameter int                QUEUE_DEPTH = 2
) (
    input logic                 clk,
    input logic                 reset,
    instruction_fetch_if.master bus
);

    localparam int CW = $clog2(QUEUE_DEPTH) + 1;

    fetch_state_e      r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_req_pc;
`ifdef IFETCH_HALT_EN
    logic              r_halted;
`endif

    logic [CW-1:0]      w_count;
    logic               w_full;
    logic               w_empty;
    logic [ADDR_W-1:0]  w_head_addr;
    logic [INSTR_W-1:0] w_head_instr;
    logic               w_resp;
    logic               w_is_halt;
    logic               w_push;
    logic               w_pop;
    logic [CW:0]        w_occ_next;
    logic               w_issue;

    // Halt-word detection on the incoming response.
    always_comb begin
        w_is_halt = 1'b0;
`ifdef IFETCH_HALT_EN
        w_is_halt = (bus.imem_data == HALT_WORD);
`endif
    end

    // Responses are only meaningful in WAIT; stray strobes in FETCH are ignored.
    assign w_resp = (r_state == ST_WAIT) && bus.imem_valid;
    assign w_pop  = !w_empty && bus.id_ready;
    assign w_push = w_resp && !bus.PCSrc && !w_is_halt && (!w_full || w_pop);

    // Occupancy after this cycle must leave a slot for the response of a new request.
    assign w_occ_next = {1'b0, w_count} + (CW+1)'(w_push) - (CW+1)'(w_pop);
    assign w_issue    = !reset && !bus.PCSrc
                     && ((r_state == ST_FETCH) || (w_resp && !w_is_halt))
                     && (w_occ_next < (CW+1)'(QUEUE_DEPTH));

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH),
        .CW    (CW)
    ) u_queue (
        .clk          (clk),
        .reset        (reset),
        .i_push       (w_push),
        .i_pop        (w_pop),
        .i_flush      (bus.PCSrc),
        .i_addr       (r_req_pc),
        .i_instr      (bus.imem_data),
        .o_full       (w_full),
        .o_empty      (w_empty),
        .o_count      (w_count),
        .o_head_addr  (w_head_addr),
        .o_head_instr (w_head_instr)
    );

    // Fetch FSM and program counter; redirect outranks everything except reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_FETCH;
            r_pc     <= RESET_PC;
            r_req_pc <= RESET_PC;
`ifdef IFETCH_HALT_EN
            r_halted <= 1'b0;
`endif
        end else if (bus.PCSrc) begin
            r_pc <= word_align(bus.BranchAddress);
            if (((r_state == ST_WAIT) || (r_state == ST_DRAIN)) && !bus.imem_valid) begin
                r_state <= ST_DRAIN;
            end else begin
                r_state <= ST_FETCH;
            end
`ifdef IFETCH_HALT_EN
            r_halted <= 1'b0;
`endif
        end else begin
            if (w_issue) begin
                r_pc     <= r_pc + PC_STEP;
                r_req_pc <= r_pc;
            end
            case (r_state)
                ST_FETCH: begin
                    if (w_issue) begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.imem_valid) begin
`ifdef IFETCH_HALT_EN
                        if (w_is_halt) begin
                            r_state  <= ST_HALT;
                            r_halted <= 1'b1;
                        end else
`endif
                        if (w_issue) begin
                            r_state <= ST_WAIT;
                        end else begin
                            r_state <= ST_FETCH;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (bus.imem_valid) begin
                        r_state <= ST_FETCH;
                    end
                end
`ifdef IFETCH_HALT_EN
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
`endif
                default: begin
                    r_state <= ST_FETCH;
                end
            endcase
        end
    end

    assign bus.imem_req    = w_issue;
    assign bus.imem_addr   = r_pc;
    assign bus.if_valid    = !w_empty;
    assign bus.Instruction = w_head_instr;
    assign bus.Address     = w_head_addr;
`ifdef IFETCH_HALT_EN
    assign bus.halted      = r_halted;
`else
    assign bus.halted      = 1'b0;
`endif

endmodule
